// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with a transmit FIFO,
// programmable bit divisor and a level interrupt that signals "all data sent".
module uart_tx_dev #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Register decode
  logic wr_data;
  logic wr_status;
  logic wr_div;
  logic wr_ctrl;

  assign wr_data   = WE && (Addr[1:0] == 2'd0);
  assign wr_status = WE && (Addr[1:0] == 2'd1);
  assign wr_div    = WE && (Addr[1:0] == 2'd2);
  assign wr_ctrl   = WE && (Addr[1:0] == 2'd3);

  // Upper address and data bits are not decoded
  logic unused_bits;
  assign unused_bits = ^{Addr[29:2], Din[31:16]};

  // Control/configuration registers
  logic [15:0] div_reg;
  logic [1:0]  ctrl_reg;
  logic        ovf_reg;
  logic        tx_en;
  logic        irq_en;

  assign tx_en  = ctrl_reg[0];
  assign irq_en = ctrl_reg[1];

  // FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf_set;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
  assign push    = wr_data && (!full || pop);
  assign ovf_set = wr_data && full && !pop;

  // Shift FSM state
  state_t      state_reg;
  state_t      state_next;
  logic [15:0] bit_cnt_reg;
  logic [15:0] bit_cnt_next;
  logic [15:0] div_cur_reg;
  logic [15:0] div_cur_next;
  logic [2:0]  idx_reg;
  logic [2:0]  idx_next;
  logic [7:0]  shreg_reg;
  logic [7:0]  shreg_next;
  logic        tx_reg;
  logic        tx_next;
  logic        irq_reg;
  logic        bit_end;
  logic        can_start;
  logic        busy;

  // div_cur_reg holds the divisor latched when the current bit began
  assign bit_end   = (bit_cnt_reg == (div_cur_reg - 16'd1));
  assign can_start = tx_en && !empty;
  assign busy      = (state_reg != IDLE);

  assign tx  = tx_reg;
  assign IRQ = irq_reg;

  // Software-visible registers: divisor, control, sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg  <= DEFAULT_DIV;
      ctrl_reg <= 2'b00;
      ovf_reg  <= 1'b0;
    end else begin
      if (wr_div) begin
        div_reg <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
      end
      if (wr_ctrl) begin
        ctrl_reg <= Din[1:0];
      end
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (wr_status && Din[3]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since count/pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= Din[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // Shift FSM next-state, pop request and next serial line value
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    div_cur_next = div_cur_reg;
    idx_next     = idx_reg;
    shreg_next   = shreg_reg;
    pop          = 1'b0;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        if (can_start) begin
          pop          = 1'b1;
          shreg_next   = fifo_mem[rd_ptr_reg];
          state_next   = START;
          bit_cnt_next = 16'd0;
          div_cur_next = div_reg;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          idx_next     = 3'd0;
          bit_cnt_next = 16'd0;
          div_cur_next = div_reg;
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_next = 16'd0;
          div_cur_next = div_reg;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_next = 16'd0;
          if (can_start) begin
            // Back-to-back frame: next start bit follows the stop bit directly
            pop          = 1'b1;
            shreg_next   = fifo_mem[rd_ptr_reg];
            state_next   = START;
            div_cur_next = div_reg;
          end else begin
            state_next = IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // tx is registered, so it is derived from the state being entered
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  // Shift FSM state register, serial line and interrupt register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 16'd0;
      div_cur_reg <= DEFAULT_DIV;
      idx_reg     <= 3'd0;
      shreg_reg   <= 8'd0;
      tx_reg      <= 1'b1;
      irq_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      div_cur_reg <= div_cur_next;
      idx_reg     <= idx_next;
      shreg_reg   <= shreg_next;
      tx_reg      <= tx_next;
      irq_reg     <= irq_en && tx_en && empty && (state_reg == IDLE);
    end
  end

  // Read mux; reads are side-effect free
  logic [3:0] count4;
  assign count4 = 4'(count_reg);

  always_comb begin
    Dout = 32'd0;
    case (Addr[1:0])
      2'd0:    Dout = 32'd0;
      2'd1:    Dout = {24'd0, count4, ovf_reg, full, empty, busy};
      2'd2:    Dout = {16'd0, div_reg};
      default: Dout = {30'd0, ctrl_reg};
    endcase
  end

endmodule
